// File: rtl/alu_exec_unit_pkg.sv
// Shared constants, result payload and branch helper for the integer execution unit.
package alu_exec_unit_pkg;

  localparam int unsigned DATA_WID = 32;
  localparam int unsigned ROB_WID  = 4;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [DATA_WID-1:0] res;
    logic                jump;
    logic [DATA_WID-1:0] target;
  } alu_result_t;

  // Branch condition on rs1/rs2; reserved funct3 codes never branch.
  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [DATA_WID-1:0] a,
                                    input logic [DATA_WID-1:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// In-order result queue: synchronous FIFO with push/pop/flush, global enable and occupancy count.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_c, do_push_c, do_pop_c;

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign full_c    = (cnt_q == CW'(DEPTH));
  assign do_pop_c  = en_i && !flush_i && pop_i && (cnt_q != '0);
  assign do_push_c = en_i && !flush_i && push_i && (!full_c || do_pop_c);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (en_i && flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push_c) wr_d = wr_q + AW'(1);
      if (do_pop_c)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  overflow_push_dropped: assert property (@(posedge clk) disable iff (!rst_n)
    !(en_i && !flush_i && push_i && full_c && !do_pop_c));

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I integer execution unit with in-order result queue feeding the result bus.
// Optional `ALU_BYPASS_EN: empty queue forwards the live result in the issue cycle.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned ROB_W  = ROB_WID
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                alu_en,
  input  logic [ROB_W-1:0]    alu_rob_pos,
  input  logic [6:0]          alu_opcode,
  input  logic [2:0]          alu_funct3,
  input  logic                alu_funct7,
  input  logic [DATA_WID-1:0] alu_val1,
  input  logic [DATA_WID-1:0] alu_val2,
  input  logic [DATA_WID-1:0] alu_imm,
  input  logic [DATA_WID-1:0] alu_pc,
  output logic                alu_full,
  output logic                alu_done,
  output logic [DATA_WID-1:0] alu_res,
  output logic [ROB_W-1:0]    alu_res_rob_pos,
  output logic                alu_jump,
  output logic [DATA_WID-1:0] alu_target,
  input  logic                cdb_gnt
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned EW = ROB_W + $bits(alu_result_t);

  alu_result_t         cmp_c, q_res_c, head_res_c;
  logic [DATA_WID-1:0] op2_c, pc4_c;
  logic [4:0]          shamt_c;
  logic                sub_c;
  logic [EW-1:0]       q_head_c;
  logic [ROB_W-1:0]    q_rob_c, head_rob_c;
  logic [CW-1:0]       count_c;
  logic                q_valid_c, push_c, pop_c, head_valid_c;

  assign op2_c   = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
  assign shamt_c = op2_c[4:0];
  assign sub_c   = (alu_opcode == OPC_OP) && alu_funct7;
  assign pc4_c   = alu_pc + DATA_WID'(4);

  // Result and branch outcome for the op on the issue port.
  always_comb begin
    cmp_c        = '0;
    cmp_c.target = pc4_c;
    case (alu_opcode)
      OPC_OP, OPC_OPIMM: begin
        case (alu_funct3)
          F3_ADD:  cmp_c.res = sub_c ? alu_val1 - op2_c : alu_val1 + op2_c;
          F3_SLL:  cmp_c.res = alu_val1 << shamt_c;
          F3_SLT:  cmp_c.res = DATA_WID'($signed(alu_val1) < $signed(op2_c));
          F3_SLTU: cmp_c.res = DATA_WID'(alu_val1 < op2_c);
          F3_XOR:  cmp_c.res = alu_val1 ^ op2_c;
          F3_SR:   cmp_c.res = alu_funct7 ? DATA_WID'($signed(alu_val1) >>> shamt_c)
                                          : alu_val1 >> shamt_c;
          F3_OR:   cmp_c.res = alu_val1 | op2_c;
          default: cmp_c.res = alu_val1 & op2_c;
        endcase
      end
      OPC_LUI:   cmp_c.res = alu_imm;
      OPC_AUIPC: cmp_c.res = alu_pc + alu_imm;
      OPC_JAL: begin
        cmp_c.res    = pc4_c;
        cmp_c.jump   = 1'b1;
        cmp_c.target = alu_pc + alu_imm;
      end
      OPC_JALR: begin
        cmp_c.res    = pc4_c;
        cmp_c.jump   = 1'b1;
        cmp_c.target = (alu_val1 + alu_imm) & ~DATA_WID'(1);
      end
      OPC_BR: begin
        cmp_c.jump   = br_taken(alu_funct3, alu_val1, alu_val2);
        cmp_c.target = alu_pc + alu_imm;
      end
      default: cmp_c.target = '0;
    endcase
  end

  assign q_valid_c = (count_c != '0);
  assign pop_c     = q_valid_c && cdb_gnt;
  assign {q_rob_c, q_res_c} = q_head_c;

`ifdef ALU_BYPASS_EN
  logic byp_c;
  // A granted bypass completes on the bus directly and never occupies a slot.
  assign byp_c        = !q_valid_c && alu_en && !rollback;
  assign push_c       = alu_en && !(byp_c && cdb_gnt);
  assign head_valid_c = q_valid_c || byp_c;
  assign head_rob_c   = byp_c ? alu_rob_pos : q_rob_c;
  assign head_res_c   = byp_c ? cmp_c : q_res_c;
`else
  assign push_c       = alu_en;
  assign head_valid_c = q_valid_c;
  assign head_rob_c   = q_rob_c;
  assign head_res_c   = q_res_c;
`endif

  alu_result_fifo #(
    .DEPTH (QDEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (rdy),
    .flush_i (rollback),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   ({alu_rob_pos, cmp_c}),
    .dout_o  (q_head_c),
    .count_o (count_c)
  );

  // One slot of headroom absorbs an issue already in flight from the RS.
  assign alu_full        = (count_c >= CW'(QDEPTH - 1));
  assign alu_done        = head_valid_c;
  assign alu_res         = head_valid_c ? head_res_c.res    : '0;
  assign alu_jump        = head_valid_c ? head_res_c.jump   : 1'b0;
  assign alu_target      = head_valid_c ? head_res_c.target : '0;
  assign alu_res_rob_pos = head_valid_c ? head_rob_c        : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed scenarios followed by randomized traffic.
module tb_alu_exec_unit;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback, alu_en, alu_funct7, cdb_gnt;
  logic [3:0]  alu_rob_pos, alu_res_rob_pos;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc, alu_res, alu_target;
  logic        alu_full, alu_done, alu_jump;

  alu_exec_unit #(.QDEPTH(QD), .ROB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_rob_pos(alu_rob_pos), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_full(alu_full), .alu_done(alu_done),
    .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos), .alu_jump(alu_jump),
    .alu_target(alu_target), .cdb_gnt(cdb_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] res;
    logic        jump;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural meaning of each opcode, computed from the instruction rules.
  function automatic exp_t ref_op(input logic [3:0] rob, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic f7,
                                  input logic [31:0] v1, input logic [31:0] v2,
                                  input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    logic [31:0] b;
    int unsigned sh;
    longint sa, sb;
    e.rob = rob; e.res = 0; e.jump = 0; e.tgt = pc + 32'd4;
    sa = longint'($signed(v1));
    sb = longint'($signed(v2));
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      b  = (opc == 7'b0110011) ? v2 : imm;
      sh = b % 32;
      case (f3)
        3'd0: e.res = (opc == 7'b0110011 && f7) ? v1 - b : v1 + b;
        3'd1: e.res = v1 << sh;
        3'd2: e.res = (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
        3'd3: e.res = ({32'd0, v1} < {32'd0, b}) ? 32'd1 : 32'd0;
        3'd4: e.res = v1 ^ b;
        3'd5: begin
          e.res = v1;
          for (int k = 0; k < 32; k++)
            if (k < sh) e.res = {f7 ? e.res[31] : 1'b0, e.res[31:1]};
        end
        3'd6: e.res = v1 | b;
        default: e.res = v1 & b;
      endcase
    end else if (opc == 7'b0110111) e.res = imm;
    else if (opc == 7'b0010111) e.res = pc + imm;
    else if (opc == 7'b1101111) begin
      e.res = pc + 32'd4; e.jump = 1; e.tgt = pc + imm;
    end else if (opc == 7'b1100111) begin
      e.res = pc + 32'd4; e.jump = 1; e.tgt = (v1 + imm) & 32'hFFFF_FFFE;
    end else if (opc == 7'b1100011) begin
      e.tgt = pc + imm;
      case (f3)
        3'd0: e.jump = (v1 == v2);
        3'd1: e.jump = (v1 != v2);
        3'd4: e.jump = (sa < sb);
        3'd5: e.jump = (sa >= sb);
        3'd6: e.jump = ({32'd0, v1} < {32'd0, v2});
        3'd7: e.jump = ({32'd0, v1} >= {32'd0, v2});
        default: e.jump = 0;
      endcase
    end else e.tgt = 0;
    return e;
  endfunction

  // Reference queue: updated from the inputs sampled at each edge.
  always @(posedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (rdy) begin
      if (rollback) exp_q.delete();
      else begin
        if (cdb_gnt && exp_q.size() != 0) void'(exp_q.pop_front());
        if (alu_en)
          exp_q.push_back(ref_op(alu_rob_pos, alu_opcode, alu_funct3, alu_funct7,
                                 alu_val1, alu_val2, alu_imm, alu_pc));
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the reference head.
  always @(negedge clk) begin
    if (mon_on) begin
      check("done", 32'(alu_done), 32'(exp_q.size() != 0));
      check("full", 32'(alu_full), 32'(exp_q.size() >= QD - 1));
      if (alu_done && exp_q.size() != 0) begin
        check("head_res", alu_res, exp_q[0].res);
        check("head_rob", 32'(alu_res_rob_pos), 32'(exp_q[0].rob));
        check("head_jump", 32'(alu_jump), 32'(exp_q[0].jump));
        check("head_target", alu_target, exp_q[0].tgt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] rob, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc);
    alu_rob_pos = rob; alu_opcode = opc; alu_funct3 = f3; alu_funct7 = f7;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc;
  endtask

  // Single issue, then sample the cycle after it was taken.
  task automatic issue1(input logic [3:0] rob, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc);
    set_op(rob, opc, f3, f7, v1, v2, imm, pc);
    alu_en = 1;
    step();
    alu_en = 0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, 32'(alu_done), 0);
    check({tag, "_full"}, 32'(alu_full), 0);
    check({tag, "_res"}, alu_res, 0);
    check({tag, "_rob"}, 32'(alu_res_rob_pos), 0);
    check({tag, "_jump"}, 32'(alu_jump), 0);
    check({tag, "_target"}, alu_target, 0);
  endtask

  logic [6:0] opcs [8];

  initial begin
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
             7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011};
    rst_n = 0; rdy = 1; rollback = 0; alu_en = 0; cdb_gnt = 0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    @(negedge clk);
    check_zero("reset");
    mon_on = 1;
    step();
    rst_n = 1;

    // Basic compute, one op at a time with grant held high.
    cdb_gnt = 1;
    issue1(3, 7'b0110011, 3'b000, 0, 5, 7, 0, 0);
    check("add_res", alu_res, 12);
    check("add_rob", 32'(alu_res_rob_pos), 3);
    check("add_done", 32'(alu_done), 1);
    check("add_jump", 32'(alu_jump), 0);
    issue1(1, 7'b0110011, 3'b000, 1, 3, 5, 0, 0);
    check("sub_res", alu_res, 32'hFFFF_FFFE);
    issue1(2, 7'b0010011, 3'b101, 1, 32'h8000_0000, 0, 32'h0000_0404, 0);
    check("srai_res", alu_res, 32'hF800_0000);
    issue1(4, 7'b0110011, 3'b011, 0, 1, 32'hFFFF_FFFF, 0, 0);
    check("sltu_res", alu_res, 1);
    issue1(5, 7'b1100011, 3'b100, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100);
    check("blt_jump", 32'(alu_jump), 1);
    check("blt_target", alu_target, 32'hF8);
    issue1(6, 7'b1100111, 3'b000, 0, 32'h1003, 0, 0, 32'h40);
    check("jalr_res", alu_res, 32'h44);
    check("jalr_target", alu_target, 32'h1002);
    step();

    // Fill without grant, then drain in order.
    cdb_gnt = 0;
    alu_en = 1;
    set_op(1, 7'b0110011, 3'b000, 0, 1, 1, 0, 0); step();
    set_op(2, 7'b0110011, 3'b000, 0, 2, 2, 0, 0); step();
    set_op(3, 7'b0110011, 3'b000, 0, 3, 3, 0, 0); step();
    alu_en = 0;
    @(negedge clk);
    check("fill_full", 32'(alu_full), 1);
    check("fill_head", 32'(alu_res_rob_pos), 1);
    cdb_gnt = 1;
    @(negedge clk);
    check("drain1_rob", 32'(alu_res_rob_pos), 2);
    check("drain1_full", 32'(alu_full), 0);
    @(negedge clk);
    check("drain2_rob", 32'(alu_res_rob_pos), 3);
    @(negedge clk);
    check("drain3_done", 32'(alu_done), 0);

    // Rollback with two queued and an issue in the same cycle.
    cdb_gnt = 0;
    step();
    alu_en = 1;
    set_op(4, 7'b0110111, 3'b000, 0, 0, 0, 32'h1234_5000, 0); step();
    set_op(5, 7'b0110111, 3'b000, 0, 0, 0, 32'h5678_9000, 0); step();
    set_op(6, 7'b0110111, 3'b000, 0, 0, 0, 32'h0000_1000, 0);
    rollback = 1;
    step();
    rollback = 0; alu_en = 0;
    @(negedge clk);
    check("rollback_done", 32'(alu_done), 0);
    @(negedge clk);
    check("rollback_lost", 32'(alu_done), 0);

    // Reset mid-stream with two queued.
    step();
    alu_en = 1;
    set_op(7, 7'b1101111, 3'b000, 0, 0, 0, 32'h20, 32'h80); step();
    set_op(8, 7'b0010111, 3'b000, 0, 0, 0, 32'h20, 32'h80); step();
    alu_en = 0; rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    check_zero("midreset");

    // rdy low freezes the queue even with grant and issue present.
    issue1(9, 7'b0110011, 3'b110, 0, 32'hF0, 32'h0F, 0, 0);
    check("rdy_pre_rob", 32'(alu_res_rob_pos), 9);
    rdy = 0; cdb_gnt = 1; alu_en = 1;
    set_op(10, 7'b0110011, 3'b000, 0, 1, 1, 0, 0);
    step(); step();
    alu_en = 0;
    @(negedge clk);
    check("rdy_hold_done", 32'(alu_done), 1);
    check("rdy_hold_rob", 32'(alu_res_rob_pos), 9);
    check("rdy_hold_res", alu_res, 32'hFF);
    rdy = 1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 49) == 0);
      cdb_gnt  = ($urandom_range(0, 2) != 0);
      alu_en   = !alu_full && ($urandom_range(0, 1) == 1);
      set_op(4'($urandom), opcs[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             $urandom, $urandom & 32'hFFFF_FFFC);
      step();
    end
    alu_en = 0; rollback = 0; rdy = 1; rst_n = 1; cdb_gnt = 1;
    repeat (QD + 2) step();
    @(negedge clk);
    check("final_empty", 32'(alu_done), 0);

    mon_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
